// File: rtl/hid_keystroke_queue_if.sv
// Report bus and character stream between the HID host side, the keystroke
// queue and the character consumer.
interface hid_keystroke_queue_if;
  logic       report;
  logic [1:0] typ;
  logic [7:0] key_modifiers;
  logic [7:0] key1;
  logic [7:0] key2;
  logic [7:0] key3;
  logic [7:0] key4;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  // Queue side: takes reports in, sources the character stream.
  modport master (
    input  report, typ, key_modifiers, key1, key2, key3, key4, out_ready,
    output out_valid, out_data
  );

  // Environment side: drives reports, sinks the character stream.
  modport slave (
    output report, typ, key_modifiers, key1, key2, key3, key4, out_ready,
    input  out_valid, out_data
  );
endinterface

// File: rtl/hid_keystroke_queue.sv
// Keyboard report to ASCII character queue. Each keyboard report is
// snapshotted, its four slots are scanned one per cycle against the previous
// report, and newly pressed keys are translated and pushed into a
// first-word-fall-through FIFO drained over valid/ready.
module hid_keystroke_queue #(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  hid_keystroke_queue_if.master        bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN0 = 3'd1,
    SCAN1 = 3'd2,
    SCAN2 = 3'd3,
    SCAN3 = 3'd4
  } state_t;

  state_t      state;
  logic [7:0]  snap [4];
  logic [7:0]  prev [4];
  logic        snap_ctrl;
  logic        snap_shift;

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic        rollover;
  logic [1:0]  slot_idx;
  logic [7:0]  cur_key;
  logic        is_new;
  logic [8:0]  xlat;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        full;
  logic        report_kbd;

  // Returns {valid, ascii}; valid=0 means the code produces no character.
  function automatic logic [8:0] translate(input logic [7:0] code,
                                           input logic shift,
                                           input logic ctrl);
    logic [8:0] r;
    r = 9'd0;
    if (code >= 8'h04 && code <= 8'h1D) begin
      if (ctrl)       r = {1'b1, code - 8'h03};
      else if (shift) r = {1'b1, code + 8'h3D};
      else            r = {1'b1, code + 8'h5D};
    end else if (code >= 8'h1E && code <= 8'h27) begin
      if (!shift) begin
        if (code == 8'h27) r = {1'b1, 8'h30};
        else               r = {1'b1, code + 8'h13};
      end else begin
        case (code)
          8'h1E:   r = {1'b1, 8'h21};
          8'h1F:   r = {1'b1, 8'h40};
          8'h20:   r = {1'b1, 8'h23};
          8'h21:   r = {1'b1, 8'h24};
          8'h22:   r = {1'b1, 8'h25};
          8'h23:   r = {1'b1, 8'h5E};
          8'h24:   r = {1'b1, 8'h26};
          8'h25:   r = {1'b1, 8'h2A};
          8'h26:   r = {1'b1, 8'h28};
          default: r = {1'b1, 8'h29};
        endcase
      end
    end else begin
      case (code)
        8'h28:   r = {1'b1, 8'h0D};
        8'h29:   r = {1'b1, 8'h1B};
        8'h2A:   r = {1'b1, 8'h08};
        8'h2B:   r = {1'b1, 8'h09};
        8'h2C:   r = {1'b1, 8'h20};
        default: r = 9'd0;
      endcase
    end
    return r;
  endfunction

  assign report_kbd = bus.report && (bus.typ == 2'd1);
  assign pop        = bus.out_valid && bus.out_ready;
  assign full       = (count == CW'(DEPTH));

  // Slot selection, new-key detection and translation for the current scan step.
  always_comb begin
    rollover = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (snap[i] == 8'h01) rollover = 1'b1;
    end

    case (state)
      SCAN1:   slot_idx = 2'd1;
      SCAN2:   slot_idx = 2'd2;
      SCAN3:   slot_idx = 2'd3;
      default: slot_idx = 2'd0;
    endcase
    cur_key = snap[slot_idx];

    is_new = (cur_key >= 8'h04);
    for (int i = 0; i < 4; i++) begin
      if (cur_key == prev[i]) is_new = 1'b0;
    end

    xlat = translate(cur_key, snap_shift, snap_ctrl);

    // A rollover report is abandoned in SCAN0 before anything is pushed.
    push_req = (state != IDLE) && !((state == SCAN0) && rollover) && is_new && xlat[8];
    // When full, the write slot is only freed by a same-cycle pop.
    push_ok  = push_req && (!full || pop);
  end

  // Report capture, scan sequencing, previous-report tracking and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      snap_ctrl  <= 1'b0;
      snap_shift <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        snap[i] <= 8'h00;
        prev[i] <= 8'h00;
      end
    end else begin
      if (report_kbd && (state != IDLE)) overflow <= 1'b1;
      if (push_req && full && !pop)      overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (report_kbd) begin
            snap[0]    <= bus.key1;
            snap[1]    <= bus.key2;
            snap[2]    <= bus.key3;
            snap[3]    <= bus.key4;
            snap_ctrl  <= bus.key_modifiers[0] | bus.key_modifiers[4];
            snap_shift <= bus.key_modifiers[1] | bus.key_modifiers[5];
            state      <= SCAN0;
          end
        end
        SCAN0:   state <= rollover ? IDLE : SCAN1;
        SCAN1:   state <= SCAN2;
        SCAN2:   state <= SCAN3;
        SCAN3: begin
          for (int i = 0; i < 4; i++) prev[i] <= snap[i];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Character storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= xlat[7:0];
  end

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rd_ptr];

endmodule

// File: tb/tb_hid_keystroke_queue.sv
// Directed self-checking bench for hid_keystroke_queue (DEPTH=16).
module tb_hid_keystroke_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] count;
  logic       overflow;
  int         errors = 0;
  int         checks = 0;

  hid_keystroke_queue_if bus_if ();

  hid_keystroke_queue #(.DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus_if.report        = 1'b0;
    bus_if.typ           = 2'd0;
    bus_if.key_modifiers = 8'h00;
    bus_if.key1          = 8'h00;
    bus_if.key2          = 8'h00;
    bus_if.key3          = 8'h00;
    bus_if.key4          = 8'h00;
  endtask

  task automatic drive_report(input logic [1:0] t, input logic [7:0] m,
                              input logic [7:0] k1, input logic [7:0] k2,
                              input logic [7:0] k3, input logic [7:0] k4);
    bus_if.report        = 1'b1;
    bus_if.typ           = t;
    bus_if.key_modifiers = m;
    bus_if.key1          = k1;
    bus_if.key2          = k2;
    bus_if.key3          = k3;
    bus_if.key4          = k4;
  endtask

  // Called at a negedge; returns at the negedge of cycle T+5 (FSM back in IDLE).
  task automatic send_report(input logic [1:0] t, input logic [7:0] m,
                             input logic [7:0] k1, input logic [7:0] k2,
                             input logic [7:0] k3, input logic [7:0] k4);
    drive_report(t, m, k1, k2, k3, k4);
    @(negedge clk);
    clear_inputs();
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    bus_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Pops one byte if available; v reports whether the FIFO had data.
  task automatic pop_byte(output logic [7:0] b, output logic v);
    v = bus_if.out_valid;
    b = bus_if.out_data;
    if (v) begin
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); end
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_single_key();
    logic [7:0] b;
    logic v;
    drive_report(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    clear_inputs();
    checks++;
    if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %b want 0", bus_if.out_valid); end
    @(negedge clk);
    checks++;
    if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL single_t2_valid: got %b want 1", bus_if.out_valid); end
    checks++;
    if (bus_if.out_data !== 8'h61) begin errors++; $display("FAIL single_t2_data: got %h want 61", bus_if.out_data); end
    checks++;
    if (count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
    repeat (3) @(negedge clk);
    pop_byte(b, v);
    checks++;
    if (!v || b !== 8'h61) begin errors++; $display("FAIL single_pop: got %h (valid %b) want 61", b, v); end
    send_report(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL single_repeat_nopush: got count %0d want 0", count); end
    send_report(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
    checks++;
    if (count !== 5'd1 || bus_if.out_data !== 8'h61) begin
      errors++; $display("FAIL single_repress: got count %0d data %h want 1 61", count, bus_if.out_data);
    end
    pop_byte(b, v);
  endtask

  task automatic test_multi_modifiers();
    logic [7:0] exp4 [4];
    logic [7:0] b;
    logic v;
    exp4 = '{8'h41, 8'h21, 8'h20, 8'h0D};
    send_report(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report(2'd1, 8'h02, 8'h04, 8'h1E, 8'h2C, 8'h28);
    checks++;
    if (count !== 5'd4) begin errors++; $display("FAIL multi_count: got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      pop_byte(b, v);
      checks++;
      if (!v || b !== exp4[i]) begin errors++; $display("FAIL multi_byte%0d: got %h want %h", i, b, exp4[i]); end
    end
    send_report(2'd1, 8'h01, 8'h06, 8'h00, 8'h00, 8'h00);
    pop_byte(b, v);
    checks++;
    if (!v || b !== 8'h03) begin errors++; $display("FAIL ctrl_c: got %h want 03", b); end
  endtask

  task automatic test_digits_and_others();
    logic [7:0] b;
    logic v;
    send_report(2'd1, 8'h00, 8'h03, 8'h2D, 8'h27, 8'h1F);
    checks++;
    if (count !== 5'd2) begin errors++; $display("FAIL digits_count: got %0d want 2", count); end
    pop_byte(b, v);
    checks++;
    if (!v || b !== 8'h30) begin errors++; $display("FAIL digit_0: got %h want 30", b); end
    pop_byte(b, v);
    checks++;
    if (!v || b !== 8'h32) begin errors++; $display("FAIL digit_2: got %h want 32", b); end
    send_report(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_report(2'd1, 8'h20, 8'h26, 8'h23, 8'h00, 8'h00);
    pop_byte(b, v);
    checks++;
    if (!v || b !== 8'h28) begin errors++; $display("FAIL rshift_9: got %h want 28", b); end
    pop_byte(b, v);
    checks++;
    if (!v || b !== 8'h5E) begin errors++; $display("FAIL rshift_6: got %h want 5e", b); end
  endtask

  task automatic test_rollover();
    logic [7:0] b;
    logic v;
    send_report(2'd1, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00);
    pop_byte(b, v);
    checks++;
    if (!v || b !== 8'h63) begin errors++; $display("FAIL roll_pre: got %h want 63", b); end
    send_report(2'd1, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01);
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL roll_nopush: got count %0d want 0", count); end
    send_report(2'd1, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00);
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL roll_prev_kept: got count %0d want 0", count); end
    send_report(2'd1, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00);
    pop_byte(b, v);
    checks++;
    if (!v || b !== 8'h62) begin errors++; $display("FAIL roll_after: got %h want 62", b); end
  endtask

  task automatic test_type_filter();
    logic [7:0] b;
    logic v;
    send_report(2'd2, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00);
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL typ2_ignored: got count %0d want 0", count); end
    // Non-keyboard report while busy must not flag overflow.
    drive_report(2'd1, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    drive_report(2'd2, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (count !== 5'd1 || overflow !== 1'b0) begin
      errors++; $display("FAIL typ2_busy: got count %0d ovf %b want 1 0", count, overflow);
    end
    pop_byte(b, v);
    checks++;
    if (!v || b !== 8'h64) begin errors++; $display("FAIL typ2_busy_byte: got %h want 64", b); end
  endtask

  task automatic test_busy_drop();
    logic [7:0] b;
    logic v;
    drive_report(2'd1, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    drive_report(2'd1, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);
    send_report(2'd1, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL busy_overflow: got %b want 1", overflow); end
    checks++;
    if (count !== 5'd2) begin errors++; $display("FAIL busy_count: got %0d want 2", count); end
    pop_byte(b, v);
    checks++;
    if (!v || b !== 8'h65) begin errors++; $display("FAIL busy_first: got %h want 65", b); end
    pop_byte(b, v);
    checks++;
    if (!v || b !== 8'h67) begin errors++; $display("FAIL busy_t5: got %h want 67", b); end
  endtask

  task automatic fill16();
    send_report(2'd1, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07);
    send_report(2'd1, 8'h00, 8'h08, 8'h09, 8'h0A, 8'h0B);
    send_report(2'd1, 8'h00, 8'h0C, 8'h0D, 8'h0E, 8'h0F);
    send_report(2'd1, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13);
  endtask

  task automatic test_fifo_full();
    logic [7:0] b;
    logic v;
    do_reset();
    fill16();
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_fill: got count %0d ovf %b want 16 0", count, overflow);
    end
    send_report(2'd1, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00);
    checks++;
    if (count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", count); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b want 1", overflow); end
    for (int i = 0; i < 16; i++) begin
      pop_byte(b, v);
      checks++;
      if (!v || b !== 8'(8'h61 + i)) begin errors++; $display("FAIL full_drain%0d: got %h want %h", i, b, 8'(8'h61 + i)); end
    end
    checks++;
    if (count !== 5'd0 || bus_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL full_empty: got count %0d valid %b want 0 0", count, bus_if.out_valid);
    end
  endtask

  task automatic test_full_with_pop();
    logic [7:0] b;
    logic v;
    do_reset();
    fill16();
    drive_report(2'd1, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    clear_inputs();
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    checks++;
    if (count !== 5'd16) begin errors++; $display("FAIL fullpop_count: got %0d want 16", count); end
    checks++;
    if (bus_if.out_data !== 8'h62) begin errors++; $display("FAIL fullpop_head: got %h want 62", bus_if.out_data); end
    repeat (3) @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %b want 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      pop_byte(b, v);
      checks++;
      if (!v || b !== 8'(8'h62 + i)) begin errors++; $display("FAIL fullpop_drain%0d: got %h want %h", i, b, 8'(8'h62 + i)); end
    end
    // Reset while in SCAN1.
    drive_report(2'd1, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    checks++;
    if (count !== 5'd1) begin errors++; $display("FAIL scan1_partial: got count %0d want 1", count); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (count !== 5'd0 || bus_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL midscan_reset: got count %0d valid %b want 0 0", count, bus_if.out_valid);
    end
    send_report(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
    checks++;
    if (count !== 5'd1 || bus_if.out_data !== 8'h61 || overflow !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got count %0d data %h ovf %b want 1 61 0", count, bus_if.out_data, overflow);
    end
  endtask

  initial begin
    clear_inputs();
    bus_if.out_ready = 1'b0;
    test_reset();
    test_single_key();
    test_multi_modifiers();
    test_digits_and_others();
    test_rollover();
    test_type_filter();
    test_busy_drop();
    test_fifo_full();
    test_full_with_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
